// File: rtl/sm_uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package sm_uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 10417;
    localparam int DEF_ADDR_W       = 6;

    // Little-endian byte lane insert.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/sm_uart_loader_if.sv
// Instruction ROM write port driven by the loader.
interface sm_uart_loader_if
    import sm_uart_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/sm_uart_loader_rx.sv
// 8N1 receiver: input synchronizer, RX FSM and bit-period down-counter.
// States: IDLE wait for start edge | START mid-start check | DATA shift 8 bits | STOP check stop bit
module sm_uart_loader_rx
    import sm_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_uart,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse,
    output logic       o_active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_byte_valid;
    logic             w_frame_err;
    logic             w_fall;
    logic             w_tc;

    assign w_fall = r_sync_d & ~r_sync2;
    assign w_tc   = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else begin
            r_sync1  <= i_uart;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (!w_tc) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!r_sync2) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = FULL_LOAD;
                    w_bit_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!w_tc) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = FULL_LOAD;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (!w_tc) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_byte_valid = r_sync2;
                    w_frame_err  = ~r_sync2;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Disabling the loader drops any frame in flight.
        if (!i_en) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_bit_nxt    = '0;
            w_byte_valid = 1'b0;
            w_frame_err  = 1'b0;
        end
    end

    assign o_byte_valid      = w_byte_valid;
    assign o_byte_data       = r_shift;
    assign o_frame_err_pulse = w_frame_err;
    assign o_active          = (r_state != ST_IDLE);

endmodule

// File: rtl/sm_uart_loader.sv
// UART program loader: assembles received bytes little-endian into 32-bit
// words and writes them to consecutive instruction ROM addresses.
module sm_uart_loader
    import sm_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_on,
    input  logic              i_uart,
    sm_uart_loader_if.master  o_rom,
    output logic              o_busy,
    output logic              o_frame_err
);

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_ferr_pulse;
    logic              w_rx_active;
    logic              w_on_rise;

    logic              r_on_d;
    logic [1:0]        r_bi;
    logic [31:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_frame_err;

    sm_uart_loader_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_en              (i_uart_on),
        .i_uart            (i_uart),
        .o_byte_valid      (w_byte_valid),
        .o_byte_data       (w_byte_data),
        .o_frame_err_pulse (w_ferr_pulse),
        .o_active          (w_rx_active)
    );

    assign w_on_rise = i_uart_on & ~r_on_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_on_d      <= 1'b0;
            r_bi        <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_on_d <= i_uart_on;
            r_we   <= 1'b0;

            if (w_byte_valid) begin
                r_word <= put_byte(r_word, r_bi, w_byte_data);
                if (r_bi == 2'd3) begin
                    r_we    <= 1'b1;
                    r_wdata <= put_byte(r_word, 2'd3, w_byte_data);
                end else begin
                    r_bi <= r_bi + 2'd1;
                end
            end

            // bi stays at 3 through the strobe so busy covers the write cycle.
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_bi   <= '0;
            end

            if (!i_uart_on) begin
                r_bi   <= '0;
                r_word <= '0;
            end

            if (w_on_rise) begin
                r_addr      <= '0;
                r_frame_err <= 1'b0;
            end else if (w_ferr_pulse) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign o_rom.we    = r_we;
    assign o_rom.addr  = r_addr;
    assign o_rom.wdata = r_wdata;
    assign o_busy      = w_rx_active | (r_bi != 2'd0);
    assign o_frame_err = r_frame_err;

endmodule
